// File: rtl/ch_measure_pkg.sv
// Shared types and sizing helpers for the binary-search channel measurement block.
package ch_measure_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SET_THR,
        ST_WAIT_DAC,
        ST_STROBE,
        ST_SAMPLE,
        ST_DECIDE,
        ST_EMIT,
        ST_NEXT,
        ST_DONE
    } state_e;

    // Vote counters are sized for the largest legal vote count so any VOTE_N fits.
    localparam int VOTE_N_MAX = 15;
    localparam int VOTE_W     = $clog2(VOTE_N_MAX + 1);

    // Width of a counter that runs 0 .. to-1.
    function automatic int to_cnt_w(input int to);
        return (to < 2) ? 1 : $clog2(to);
    endfunction

endpackage

// File: rtl/ch_measure_bsearch_stb_vote.sv
// Strobe handshake, per-strobe timeout and majority vote for one comparator decision.
// decision_valid_o fires in the sample cycle of the last vote; decision_o is the majority.
module stb_vote
    import ch_measure_pkg::*;
#(
    parameter int VOTE_N = 3,
    parameter int STB_TO = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic strobe_i,
    input  logic sample_i,
    input  logic stb_valid_i,
    input  logic cmp_out_i,
    output logic stb_req_o,
    output logic stb_seen_o,
    output logic timeout_o,
    output logic decision_valid_o,
    output logic decision_o
);

    localparam int TO_W = to_cnt_w(STB_TO);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(STB_TO - 1);
    localparam logic [VOTE_W-1:0] VOTE_LAST = VOTE_W'(VOTE_N);
    localparam logic [VOTE_W-1:0] VOTE_MAJ  = VOTE_W'(VOTE_N / 2);

    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [VOTE_W-1:0] votes_q, votes_d;
    logic [VOTE_W-1:0] ones_q, ones_d;

    always_comb begin
        // The timeout window restarts on every strobe request.
        to_cnt_d = (strobe_i && !stb_valid_i) ? to_cnt_q + 1'b1 : '0;
        votes_d  = votes_q;
        ones_d   = ones_q;
        if (clr_i) begin
            votes_d = '0;
            ones_d  = '0;
        end else if (sample_i) begin
            votes_d = votes_q + 1'b1;
            ones_d  = ones_q + VOTE_W'(cmp_out_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
            votes_q  <= '0;
            ones_q   <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
            votes_q  <= votes_d;
            ones_q   <= ones_d;
        end
    end

    assign stb_req_o        = strobe_i;
    assign stb_seen_o       = strobe_i && stb_valid_i;
    assign timeout_o        = strobe_i && !stb_valid_i && (to_cnt_q == TO_LAST);
    assign decision_valid_o = sample_i && (votes_d == VOTE_LAST);
    assign decision_o       = (ones_d > VOTE_MAJ);

endmodule

// File: rtl/ch_measure_bsearch.sv
// Delay-code sweep controller: binary-search threshold per code with majority-voted
// comparator decisions; one point per code on a valid/ready stream, held until accepted.
module ch_measure_bsearch
    import ch_measure_pkg::*;
#(
    parameter int THR_W   = 16,
    parameter int DCODE_W = 10,
    parameter int VOTE_N  = 3,
    parameter int STB_TO  = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic [DCODE_W-1:0] d_start_i,
    input  logic [DCODE_W-1:0] d_stop_i,
    input  logic [DCODE_W-1:0] d_step_i,
    output logic [DCODE_W-1:0] d_code_o,
    output logic [THR_W-1:0]   threshold_o,
    output logic               threshold_wre_o,
    input  logic               threshold_rdy_i,
    output logic               stb_req_o,
    input  logic               stb_valid_i,
    input  logic               cmp_out_i,
    output logic               point_valid_o,
    input  logic               point_ready_i,
    output logic [DCODE_W-1:0] point_t_o,
    output logic [THR_W-1:0]   point_v_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam logic [THR_W-1:0]   BIT_MSB  = {1'b1, {(THR_W-1){1'b0}}};
    localparam logic [DCODE_W-1:0] STEP_MIN = DCODE_W'(1);

    state_e             state_q, state_d;
    logic               run_q;
    logic [DCODE_W-1:0] start_q, start_d;
    logic [DCODE_W-1:0] stop_q, stop_d;
    logic [DCODE_W-1:0] step_q, step_d;
    logic [DCODE_W-1:0] d_code_q, d_code_d;
    logic [THR_W-1:0]   thr_q, thr_d;
    logic [THR_W-1:0]   result_q, result_d;
    logic [THR_W-1:0]   bit_q, bit_d;
    logic               dec_q, dec_d;
    logic               err_q, err_d;
    logic               arm_q;

    logic               run_rise;
    logic [DCODE_W-1:0] step_eff;
    logic [DCODE_W:0]   next_code;

    logic sv_req, sv_seen, sv_timeout, sv_dec_vld, sv_dec;

    stb_vote #(
        .VOTE_N (VOTE_N),
        .STB_TO (STB_TO)
    ) u_stb_vote (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clr_i            (state_q == ST_WAIT_DAC),
        .strobe_i         (state_q == ST_STROBE),
        .sample_i         (state_q == ST_SAMPLE),
        .stb_valid_i      (stb_valid_i),
        .cmp_out_i        (cmp_out_i),
        .stb_req_o        (sv_req),
        .stb_seen_o       (sv_seen),
        .timeout_o        (sv_timeout),
        .decision_valid_o (sv_dec_vld),
        .decision_o       (sv_dec)
    );

    assign run_rise  = run_i && !run_q;
    assign step_eff  = (step_q == '0) ? STEP_MIN : step_q;
    assign next_code = {1'b0, d_code_q} + {1'b0, step_eff};

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        stop_d   = stop_q;
        step_d   = step_q;
        d_code_d = d_code_q;
        thr_d    = thr_q;
        result_d = result_q;
        bit_d    = bit_q;
        dec_d    = dec_q;
        err_d    = err_q;

        if (state_q != ST_IDLE && !run_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run_rise) begin
                        state_d = ST_LOAD;
                        err_d   = 1'b0;
                        start_d = d_start_i;
                        stop_d  = d_stop_i;
                        step_d  = d_step_i;
                    end
                end
                ST_LOAD: begin
                    d_code_d = start_q;
                    result_d = '0;
                    bit_d    = BIT_MSB;
                    state_d  = (start_q > stop_q) ? ST_DONE : ST_SET_THR;
                end
                ST_SET_THR: state_d = ST_WAIT_DAC;
                ST_WAIT_DAC: begin
                    // arm_q masks the cycle where the DAC is still reacting to wre.
                    if (arm_q && threshold_rdy_i) state_d = ST_STROBE;
                end
                ST_STROBE: begin
                    if (sv_timeout) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (sv_seen) begin
                        state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (sv_dec_vld) begin
                        dec_d   = sv_dec;
                        state_d = ST_DECIDE;
                    end else begin
                        state_d = ST_STROBE;
                    end
                end
                ST_DECIDE: begin
                    if (dec_q) result_d = result_q | bit_q;
                    if (bit_q[0]) begin
                        state_d = ST_EMIT;
                    end else begin
                        bit_d   = bit_q >> 1;
                        state_d = ST_SET_THR;
                    end
                end
                ST_EMIT: begin
                    if (point_ready_i) state_d = ST_NEXT;
                end
                ST_NEXT: begin
                    if (next_code[DCODE_W] || (next_code[DCODE_W-1:0] > stop_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        d_code_d = next_code[DCODE_W-1:0];
                        result_d = '0;
                        bit_d    = BIT_MSB;
                        state_d  = ST_SET_THR;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Threshold is loaded on entry so it is already valid during the wre pulse.
        if (state_d == ST_SET_THR) thr_d = result_d | bit_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            run_q    <= 1'b0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            d_code_q <= '0;
            thr_q    <= '0;
            result_q <= '0;
            bit_q    <= '0;
            dec_q    <= 1'b0;
            err_q    <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_i;
            start_q  <= start_d;
            stop_q   <= stop_d;
            step_q   <= step_d;
            d_code_q <= d_code_d;
            thr_q    <= thr_d;
            result_q <= result_d;
            bit_q    <= bit_d;
            dec_q    <= dec_d;
            err_q    <= err_d;
            arm_q    <= (state_q == ST_WAIT_DAC);
        end
    end

    assign d_code_o        = d_code_q;
    assign threshold_o     = thr_q;
    assign threshold_wre_o = (state_q == ST_SET_THR);
    assign stb_req_o       = sv_req;
    assign point_valid_o   = (state_q == ST_EMIT);
    assign point_t_o       = d_code_q;
    assign point_v_o       = result_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = (state_q == ST_DONE);
    assign err_o           = err_q;

endmodule

// File: tb/tb_ch_measure_bsearch.sv
// Scoreboard bench: DAC/strobe/comparator environment model, expected points queued by
// the stimulus and popped by a monitor on every accepted point.
module tb_ch_measure_bsearch;

    localparam int THR_W   = 16;
    localparam int DCODE_W = 10;
    localparam int VOTE_N  = 3;
    localparam int STB_TO  = 1024;

    logic               clk_i, rst_i, run_i;
    logic [DCODE_W-1:0] d_start_i, d_stop_i, d_step_i;
    logic [DCODE_W-1:0] d_code_o;
    logic [THR_W-1:0]   threshold_o;
    logic               threshold_wre_o, threshold_rdy_i;
    logic               stb_req_o, stb_valid_i, cmp_out_i;
    logic               point_valid_o, point_ready_i;
    logic [DCODE_W-1:0] point_t_o;
    logic [THR_W-1:0]   point_v_o;
    logic               busy_o, done_o, err_o;

    ch_measure_bsearch #(
        .THR_W (THR_W), .DCODE_W (DCODE_W), .VOTE_N (VOTE_N), .STB_TO (STB_TO)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i), .run_i (run_i),
        .d_start_i (d_start_i), .d_stop_i (d_stop_i), .d_step_i (d_step_i),
        .d_code_o (d_code_o), .threshold_o (threshold_o),
        .threshold_wre_o (threshold_wre_o), .threshold_rdy_i (threshold_rdy_i),
        .stb_req_o (stb_req_o), .stb_valid_i (stb_valid_i), .cmp_out_i (cmp_out_i),
        .point_valid_o (point_valid_o), .point_ready_i (point_ready_i),
        .point_t_o (point_t_o), .point_v_o (point_v_o),
        .busy_o (busy_o), .done_o (done_o), .err_o (err_o)
    );

    typedef struct packed {
        logic [DCODE_W-1:0] t;
        logic [THR_W-1:0]   v;
    } pt_t;

    pt_t exp_q[$];
    int  tests = 0, fails = 0, cyc = 0;
    int  done_cnt = 0, pt_cnt = 0, wre_cnt = 0, stb_cnt = 0;
    bit  stb_en = 1, noise = 0, sine = 0;
    logic [THR_W-1:0] static_lvl = 16'h1234;
    int  dac_busy, vote_idx;

    // 32768 + 16384*sin(k*22.5 deg), rounded.
    logic [THR_W-1:0] sine_tab [16] = '{
        16'd32768, 16'd39038, 16'd44353, 16'd47905, 16'd49152, 16'd47905, 16'd44353, 16'd39038,
        16'd32768, 16'd26498, 16'd21183, 16'd17631, 16'd16384, 16'd17631, 16'd21183, 16'd26498
    };

    function automatic logic [THR_W-1:0] level_at(input logic [DCODE_W-1:0] t);
        return sine ? sine_tab[t[9:6]] : static_lvl;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Environment: DAC drops ready for a few cycles after each write; stb_gen answers
    // each request with a one-cycle valid and a latched comparator result.
    initial begin
        threshold_rdy_i = 1'b1;
        stb_valid_i     = 1'b0;
        cmp_out_i       = 1'b0;
        dac_busy        = 0;
        vote_idx        = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (threshold_wre_o) begin
                threshold_rdy_i = 1'b0;
                dac_busy        = 3;
                vote_idx        = 0;
            end else if (dac_busy > 0) begin
                dac_busy--;
                threshold_rdy_i = (dac_busy == 0);
            end
            if (stb_valid_i) begin
                stb_valid_i = 1'b0;
            end else if (stb_req_o && stb_en) begin
                stb_valid_i = 1'b1;
                cmp_out_i   = (level_at(d_code_o) >= threshold_o);
                if (noise && (vote_idx % 3 == 1)) cmp_out_i = ~cmp_out_i;
                vote_idx++;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        pt_t e;
        int  dv;
        forever begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
            if (threshold_wre_o) wre_cnt++;
            if (stb_valid_i) stb_cnt++;
            if (point_valid_o && point_ready_i && run_i) begin
                pt_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_point: got t=%0d v=0x%0h, none expected", point_t_o, point_v_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("point_t", 32'(point_t_o), 32'(e.t));
                    tests++;
                    dv = int'(point_v_o) - int'(e.v);
                    if (dv > 1 || dv < -1) begin
                        fails++;
                        $display("FAIL point_v: t=%0d got 0x%0h, expected 0x%0h +-1", e.t, point_v_o, e.v);
                    end
                end
            end
        end
    end

    task automatic do_sweep(input logic [DCODE_W-1:0] s, input logic [DCODE_W-1:0] e,
                            input logic [DCODE_W-1:0] st, input int budget);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        d_start_i = s;
        d_stop_i  = e;
        d_step_i  = st;
        run_i     = 1'b1;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("sweep_done_in_budget", 32'(n < budget), 32'd1);
        run_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p0, dn0, w0, s0, c_req;
        rst_i = 1'b1; run_i = 1'b0; point_ready_i = 1'b1;
        d_start_i = '0; d_stop_i = '0; d_step_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_ctrl", 32'({threshold_wre_o, stb_req_o, point_valid_o, busy_o, done_o, err_o}), 32'd0);
        chk("reset_dcode", 32'(d_code_o), 32'd0);
        chk("reset_thr", 32'(threshold_o), 32'd0);
        chk("reset_point", 32'({point_t_o, point_v_o}), 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Static level, single code.
        w0 = wre_cnt; s0 = stb_cnt; dn0 = done_cnt; p0 = pt_cnt;
        exp_q.push_back(pt_t'{t: 10'd0, v: 16'h1234});
        do_sweep(10'd0, 10'd0, 10'd1, 2000);
        chk("t1_points", 32'(pt_cnt - p0), 32'd1);
        chk("t1_wre_pulses", 32'(wre_cnt - w0), 32'd16);
        chk("t1_strobes", 32'(stb_cnt - s0), 32'd48);
        chk("t1_done", 32'(done_cnt - dn0), 32'd1);

        // Sine sweep 0..1023 step 64: last point at 960, carry ends the sweep.
        sine = 1;
        p0 = pt_cnt;
        for (int k = 0; k < 16; k++) exp_q.push_back(pt_t'{t: 10'(k * 64), v: sine_tab[k]});
        do_sweep(10'd0, 10'd1023, 10'd64, 20000);
        sine = 0;
        chk("t2_points", 32'(pt_cnt - p0), 32'd16);
        chk("t2_queue_drained", 32'(exp_q.size()), 32'd0);

        // One vote in three flipped.
        noise = 1; static_lvl = 16'h8000;
        exp_q.push_back(pt_t'{t: 10'd0, v: 16'h8000});
        do_sweep(10'd0, 10'd0, 10'd1, 3000);
        noise = 0;

        // Strobe timeout.
        stb_en = 0; static_lvl = 16'h1234; dn0 = done_cnt;
        d_start_i = '0; d_stop_i = '0; d_step_i = 10'd1; run_i = 1'b1;
        n = 0;
        while (!stb_req_o && n < 200) begin @(posedge clk_i); #1; n++; end
        chk("t4_req_seen", 32'(n < 200), 32'd1);
        c_req = cyc;
        n = 0;
        while (!err_o && n < 2000) begin @(posedge clk_i); #1; n++; end
        chk("t4_err_set", 32'(err_o), 32'd1);
        chk("t4_err_latency", 32'(cyc - c_req), 32'(STB_TO));
        chk("t4_busy_low", 32'(busy_o), 32'd0);
        chk("t4_req_low", 32'(stb_req_o), 32'd0);
        chk("t4_no_done", 32'(done_cnt - dn0), 32'd0);
        stb_en = 1; run_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("t4_err_sticky", 32'(err_o), 32'd1);
        exp_q.push_back(pt_t'{t: 10'd0, v: 16'h1234});
        run_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t4_err_cleared", 32'(err_o), 32'd0);
        do_sweep(10'd0, 10'd0, 10'd1, 2000);

        // Backpressure: point held 50 cycles.
        point_ready_i = 1'b0; static_lvl = 16'h5555; p0 = pt_cnt;
        exp_q.push_back(pt_t'{t: 10'd0, v: 16'h5555});
        d_start_i = '0; d_stop_i = '0; d_step_i = 10'd1; run_i = 1'b1;
        n = 0;
        while (!point_valid_o && n < 2000) begin @(posedge clk_i); #1; n++; end
        chk("t5_valid_seen", 32'(point_valid_o), 32'd1);
        for (int i = 0; i < 50; i++) begin
            chk("t5_valid_held", 32'(point_valid_o), 32'd1);
            chk("t5_t_stable", 32'(point_t_o), 32'd0);
            chk("t5_v_stable", 32'(point_v_o), 32'h5555);
            @(posedge clk_i);
            #1;
        end
        point_ready_i = 1'b1;
        do_sweep(10'd0, 10'd0, 10'd1, 100);
        chk("t5_one_transfer", 32'(pt_cnt - p0), 32'd1);

        // Abort during STROBE.
        p0 = pt_cnt; dn0 = done_cnt;
        d_start_i = '0; d_stop_i = '0; d_step_i = 10'd1; run_i = 1'b1;
        n = 0;
        while (!stb_req_o && n < 200) begin @(posedge clk_i); #1; n++; end
        chk("t6_req_seen", 32'(stb_req_o), 32'd1);
        run_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("t6_busy_low", 32'(busy_o), 32'd0);
        chk("t6_req_low", 32'(stb_req_o), 32'd0);
        chk("t6_wre_low", 32'(threshold_wre_o), 32'd0);
        repeat (20) @(posedge clk_i);
        #1;
        chk("t6_no_point", 32'(pt_cnt - p0), 32'd0);
        chk("t6_no_done", 32'(done_cnt - dn0), 32'd0);

        // Start beyond stop: done with no points.
        p0 = pt_cnt; dn0 = done_cnt;
        do_sweep(10'd10, 10'd5, 10'd1, 100);
        chk("t7_done", 32'(done_cnt - dn0), 32'd1);
        chk("t7_no_point", 32'(pt_cnt - p0), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ch_measure_bsearch.md
Name: ch_measure_bsearch

Overview:
- Next-generation channel measurement controller for the measure unit.
- Sweeps the strobe delay code from a programmable start to a programmable stop in programmable steps. For each delay code it finds the signal level with a THR_W-bit binary-search threshold, instead of a linear threshold sweep.
- Each comparator decision is a majority vote over VOTE_N strobes, which rejects comparator noise.
- Sits between the stb_gen strobe generator, the threshold DAC, the comparator and the point sink. Results leave through a valid/ready point stream.

Parameters:
- THR_W, 16, DAC threshold width in bits (binary-search depth).
- DCODE_W, 10, delay-line code width.
- VOTE_N, 3, strobes per comparator decision; odd, 1..15.
- STB_TO, 1024, cycles allowed from stb_req_o rise to stb_valid_i before timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- run_i  in  1  level; rise starts a sweep, low aborts
- d_start_i  in  DCODE_W  first delay code
- d_stop_i  in  DCODE_W  last permitted delay code
- d_step_i  in  DCODE_W  delay increment; 0 is treated as 1
- d_code_o  out  DCODE_W  current delay code to the delay line
- threshold_o  out  THR_W  DAC code
- threshold_wre_o  out  1  one-cycle DAC write pulse
- threshold_rdy_i  in  1  DAC settled
- stb_req_o  out  1  strobe request
- stb_valid_i  in  1  strobe issued
- cmp_out_i  in  1  latched comparator output (1 means sig >= threshold)
- point_valid_o  out  1  point available
- point_ready_i  in  1  sink accepts point
- point_t_o  out  DCODE_W  delay code of the point
- point_v_o  out  THR_W  measured level
- busy_o  out  1  sweep in progress
- done_o  out  1  one-cycle pulse at sweep completion
- err_o  out  1  sticky strobe-timeout flag; cleared by reset or by the next run_i rise

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Inputs d_start_i, d_stop_i and d_step_i are captured on the run_i rise and are ignored afterwards.
- FSM states: IDLE, LOAD, SET_THR, WAIT_DAC, STROBE, SAMPLE, DECIDE, EMIT, NEXT, DONE.
- IDLE: on run_i 0->1, go to LOAD. err_o is cleared on this rise.
- LOAD:
  - d_code_o = d_start_i; result = 0; bit = MSB.
  - If d_start_i > d_stop_i, go straight to DONE with no points.
- SET_THR:
  - threshold_o = result | bit; threshold_wre_o = 1 for exactly one cycle.
- WAIT_DAC:
  - threshold_rdy_i is ignored in the first cycle after the wre pulse (the DAC drops rdy in response to wre).
  - From the second cycle on, leave when threshold_rdy_i = 1.
  - vote counter = 0; ones counter = 0.
- STROBE:
  - Hold stb_req_o = 1 until stb_valid_i = 1 is seen; stb_req_o drops in the next cycle.
  - If STB_TO cycles elapse without stb_valid_i: err_o = 1, abort to IDLE, no done_o.
- SAMPLE:
  - One cycle after stb_valid_i, sample cmp_out_i; increment ones if it is 1; increment the vote counter.
  - If vote counter < VOTE_N, return to STROBE.
- DECIDE:
  - If ones > VOTE_N/2 (majority), keep bit in result.
  - If bit is the LSB, go to EMIT; otherwise shift bit right and go to SET_THR.
- EMIT:
  - point_valid_o = 1 with point_t_o = d_code_o and point_v_o = result.
  - Outputs are held stable until the cycle with point_ready_i = 1; that cycle is the transfer, and valid drops after it.
- NEXT:
  - Compute next = d_code_o + max(d_step_i, 1) in DCODE_W+1 bits.
  - If next > d_stop_i or the carry is set, go to DONE. Otherwise d_code_o = next, result = 0, bit = MSB, go to SET_THR.
- DONE: done_o = 1 for one cycle, then go to IDLE.
- busy_o = 1 in every state except IDLE.
- Abort:
  - run_i = 0 in any non-IDLE state returns the FSM to IDLE at the next edge.
  - All strobe, wre and valid outputs deassert; no done_o; any pending point is dropped.
  - d_code_o and threshold_o hold their last values.
- Reset mid-sweep has the same effect as abort and also returns every output to 0.
- Simultaneous run_i fall and point_ready_i in EMIT: abort wins; the point is treated as not transferred.
- Points per sweep: floor((stop - start) / step) + 1.
- DAC writes per point: THR_W.
- Strobes per point: THR_W * VOTE_N.

Decomposition:
- Package ch_measure_pkg holds:
  - the state enum typedef;
  - the localparam VOTE_W = $clog2(VOTE_N+1);
  - the timeout counter width function.
- One natural sub-module: stb_vote, which owns the strobe handshake, the timeout counter and the majority counter. It returns decision_valid, decision and timeout to the main FSM.

Test Plan:
- Static signal at 0x1234, VOTE_N=3, start=0, stop=0, step=1 -> exactly one point (t=0, v=0x1234); 16 wre pulses; 48 strobes; done_o pulses once.
- Sine signal driven through the stb_gen/comparator model, start=0, stop=1023, step=64 -> 16 points at t = 0, 64, ..., 960; each v within ±1 LSB of the model value; no point after t=960.
- Comparator flips one vote in three on every decision, VOTE_N=3, static level 0x8000 -> result still 0x8000.
- stb_valid_i tied low -> err_o = 1 exactly STB_TO cycles after stb_req_o rises; busy_o = 0; no done_o; next run_i rise clears err_o.
- point_ready_i held low for 50 cycles -> point_valid_o held and point_t_o/point_v_o stable for all 50 cycles; exactly one transfer.
- run_i dropped during STROBE -> IDLE next cycle; stb_req_o = 0; no point and no done_o; start=10, stop=5 -> done_o with zero points.
